// File: rtl/q4_pkg.sv
// Shared definitions for the q4 lamp sequencer.
//   phase_e    : sequencer state, its encoding is also the PHASE debug output.
//   LAMP_*     : bit index of red/yellow/green inside a per-approach lamp vector.
//   DEF_*      : default timing constants, in ticks (CLK_DIV in clock cycles).
//   cnt_width  : width needed to count 0..maxv-1, never less than 1 bit.
package q4_pkg;

  typedef enum logic [2:0] {
    ALLRED_N  = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALLRED_L  = 3'd3,
    LO_GREEN  = 3'd4,
    LO_YELLOW = 3'd5
  } phase_e;

  localparam int LAMP_R = 0;
  localparam int LAMP_Y = 1;
  localparam int LAMP_G = 2;

  localparam int DEF_CLK_DIV     = 1;
  localparam int DEF_T_MIN_GREEN = 8;
  localparam int DEF_T_YELLOW    = 3;
  localparam int DEF_T_ALL_RED   = 1;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic int cnt_width(input int maxv);
    return (maxv > 1) ? $clog2(maxv) : 1;
  endfunction

endpackage

// File: rtl/q4_tick_gen.sv
// Prescaler producing one timing tick every CLK_DIV clock cycles.
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   i_clear : restarts the prescaler (driven on every state entry)
//   o_tick  : high on the last cycle of each CLK_DIV-cycle period
module q4_tick_gen #(
  parameter int CLK_DIV = 1,
  parameter int W       = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam logic [W-1:0] C_LAST = W'(CLK_DIV - 1);

  logic [W-1:0] r_pre;

  assign o_tick = (r_pre == C_LAST);

  always_ff @(posedge clk) begin
    if (rst || i_clear || o_tick) r_pre <= '0;
    else                          r_pre <= r_pre + W'(1);
  end

endmodule

// File: rtl/q4_semaforo_seq.sv
// Timed lamp sequencer downstream of the q4_via controller. Turns the N_S / L_O
// right-of-way requests into safe lamp sequences with minimum green, yellow and
// all-red clearance times.
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   N_S, L_O          : right-of-way requests (registered once on entry)
//   NS_R/NS_Y/NS_G    : north-south lamps
//   LO_R/LO_Y/LO_G    : east-west lamps
//   PHASE             : current state encoding (phase_e)
module q4_semaforo_seq
  import q4_pkg::*;
#(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int T_MIN_GREEN = DEF_T_MIN_GREEN,
  parameter int T_YELLOW    = DEF_T_YELLOW,
  parameter int T_ALL_RED   = DEF_T_ALL_RED
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       N_S,
  input  logic       L_O,
  output logic       NS_R,
  output logic       NS_Y,
  output logic       NS_G,
  output logic       LO_R,
  output logic       LO_Y,
  output logic       LO_G,
  output logic [2:0] PHASE
);

  localparam int CW = cnt_width(max4(CLK_DIV, T_MIN_GREEN, T_YELLOW, T_ALL_RED));

  localparam logic [CW-1:0] C_RED_LAST = CW'(T_ALL_RED - 1);
  localparam logic [CW-1:0] C_GRN_LAST = CW'(T_MIN_GREEN - 1);
  localparam logic [CW-1:0] C_YEL_LAST = CW'(T_YELLOW - 1);

  logic          r_req_ns;
  logic          r_req_lo;
  phase_e        r_state;
  logic [CW-1:0] r_cnt;

  phase_e        w_next;
  logic          w_tick;
  logic          w_enter;
  logic          w_green;
  logic [2:0]    w_ns;
  logic [2:0]    w_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_ns <= 1'b0;
      r_req_lo <= 1'b0;
    end else begin
      r_req_ns <= N_S;
      r_req_lo <= L_O;
    end
  end

  // Prescaler restarts together with the phase counter whenever a new state
  // is entered, so every timed state lasts exactly N*CLK_DIV cycles.
  q4_tick_gen #(
    .CLK_DIV (CLK_DIV),
    .W       (CW)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_enter),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ALLRED_N;
    else     r_state <= w_next;
  end

  // Greens only give way to an unambiguous opposing request; yellow and
  // all-red always run to completion regardless of the requests.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ALLRED_N:  if (w_tick && r_cnt == C_RED_LAST) w_next = NS_GREEN;
      NS_GREEN:  if (w_tick && r_cnt == C_GRN_LAST && r_req_lo && !r_req_ns)
                   w_next = NS_YELLOW;
      NS_YELLOW: if (w_tick && r_cnt == C_YEL_LAST) w_next = ALLRED_L;
      ALLRED_L:  if (w_tick && r_cnt == C_RED_LAST) w_next = LO_GREEN;
      LO_GREEN:  if (w_tick && r_cnt == C_GRN_LAST && r_req_ns && !r_req_lo)
                   w_next = LO_YELLOW;
      LO_YELLOW: if (w_tick && r_cnt == C_YEL_LAST) w_next = ALLRED_N;
      default:   w_next = ALLRED_N;
    endcase
  end

  assign w_enter = (w_next != r_state);
  assign w_green = (r_state == NS_GREEN) || (r_state == LO_GREEN);

  // In green the counter parks at the minimum so the hold can be indefinite.
  always_ff @(posedge clk) begin
    if (rst || w_enter) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      if (!w_green || r_cnt != C_GRN_LAST) r_cnt <= r_cnt + CW'(1);
    end
  end

  always_comb begin
    w_ns         = '0;
    w_lo         = '0;
    w_ns[LAMP_R] = 1'b1;
    w_lo[LAMP_R] = 1'b1;
    case (r_state)
      NS_GREEN:  begin w_ns = '0; w_ns[LAMP_G] = 1'b1; end
      NS_YELLOW: begin w_ns = '0; w_ns[LAMP_Y] = 1'b1; end
      LO_GREEN:  begin w_lo = '0; w_lo[LAMP_G] = 1'b1; end
      LO_YELLOW: begin w_lo = '0; w_lo[LAMP_Y] = 1'b1; end
      default:   ;
    endcase
  end

  assign NS_R  = w_ns[LAMP_R];
  assign NS_Y  = w_ns[LAMP_Y];
  assign NS_G  = w_ns[LAMP_G];
  assign LO_R  = w_lo[LAMP_R];
  assign LO_Y  = w_lo[LAMP_Y];
  assign LO_G  = w_lo[LAMP_G];
  assign PHASE = r_state;

endmodule
